// File: rtl/obstacle_sprite_loader.sv
// Unpacks streamed pixel bytes into sequential sprite RAM writes.
// Define OBSTACLE_LOADER_TRANSPARENT_SKIP_EN to suppress writes of zero pixels.
module obstacle_sprite_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   pix_count,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] addr_w,
  output logic [DATA_WIDTH-1:0] din,
  output logic                  busy,
  output logic                  done
);

  localparam int PPB = 8 / DATA_WIDTH;
  localparam int LW  = $clog2(PPB + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BYTE,
    UNPACK,
    FINISH
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            byte_q, byte_d;
  logic [LW-1:0]         lane_q, lane_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;

  logic                  s_ready_q, s_ready_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_w_q, addr_w_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [DATA_WIDTH-1:0] pix_sel;
  logic [DATA_WIDTH-1:0] pres_pix;
  logic                  present;

  always_comb begin
    pix_sel = '0;
    for (int i = 0; i < PPB; i++) begin
      if (lane_q == LW'(i)) begin
        pix_sel = byte_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Counters point at the next pixel; output regs hold the write being presented.
  always_comb begin
    state_d  = state_q;
    byte_d   = byte_q;
    lane_d   = lane_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    we_d     = 1'b0;
    addr_w_d = addr_w_q;
    din_d    = din_q;
    present  = 1'b0;
    pres_pix = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          rem_d   = pix_count;
          addr_d  = '0;
          lane_d  = '0;
          state_d = (pix_count == '0) ? FINISH : WAIT_BYTE;
        end
      end
      WAIT_BYTE: begin
        if (s_valid && s_ready_q) begin
          byte_d   = s_data;
          present  = 1'b1;
          pres_pix = s_data[DATA_WIDTH-1:0];
          lane_d   = LW'(1);
          state_d  = UNPACK;
        end
      end
      UNPACK: begin
        if (rem_q == '0) begin
          state_d = FINISH;
        end else if (lane_q == LW'(PPB)) begin
          state_d = WAIT_BYTE;
        end else begin
          present  = 1'b1;
          pres_pix = pix_sel;
          lane_d   = lane_q + LW'(1);
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
    endcase

    if (present) begin
`ifdef OBSTACLE_LOADER_TRANSPARENT_SKIP_EN
      we_d     = |pres_pix;
`else
      we_d     = 1'b1;
`endif
      addr_w_d = addr_q;
      din_d    = pres_pix;
      addr_d   = addr_q + ADDR_WIDTH'(1);
      rem_d    = rem_q - (ADDR_WIDTH+1)'(1);
    end

    s_ready_d = (state_d == WAIT_BYTE);
    busy_d    = (state_d == WAIT_BYTE) || (state_d == UNPACK);
    done_d    = (state_d == FINISH);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      byte_q    <= '0;
      lane_q    <= '0;
      addr_q    <= '0;
      rem_q     <= '0;
      s_ready_q <= 1'b0;
      we_q      <= 1'b0;
      addr_w_q  <= '0;
      din_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      byte_q    <= byte_d;
      lane_q    <= lane_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      s_ready_q <= s_ready_d;
      we_q      <= we_d;
      addr_w_q  <= addr_w_d;
      din_q     <= din_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign s_ready = s_ready_q;
  assign we      = we_q;
  assign addr_w  = addr_w_q;
  assign din     = din_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_obstacle_sprite_loader.sv
// Scoreboard bench for obstacle_sprite_loader: expected RAM writes and
// completion pulses are queued by stimulus and consumed by a monitor.
module tb_obstacle_sprite_loader;

  localparam int AW  = 10;
  localparam int DW  = 2;
  localparam int PPB = 4;
`ifdef OBSTACLE_LOADER_TRANSPARENT_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   pix_count = '0;
  logic [7:0]    s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          we;
  logic [AW-1:0] addr_w;
  logic [DW-1:0] din;
  logic          busy;
  logic          done;

  obstacle_sprite_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .pix_count(pix_count),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .we(we), .addr_w(addr_w), .din(din), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t        wq[$];
  bit         dq[$];
  logic [7:0] bq[$];
  int         n_chk = 0;
  int         n_pass = 0;
  int         done_cnt = 0;
  bit         prev_we = 1'b0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic fail(string nm);
    n_chk++;
    $display("FAIL %s: got timeout/unexpected expected none", nm);
  endtask

  function automatic bit wr_en(logic [1:0] p);
    return (p != 2'b00) || !SKIP;
  endfunction

  // Monitor: every write and every done pulse is consumed from the queues.
  always @(negedge clk) begin
    wr_t e;
    if (reset) begin
      prev_we = 1'b0;
    end else begin
      if (we) begin
        if (wq.size() == 0) begin
          fail("unexpected_write");
        end else begin
          e = wq.pop_front();
          chk("wr_addr", 64'(addr_w), 64'(e.a));
          chk("wr_data", 64'(din), 64'(e.d));
        end
      end
      if (done) begin
        done_cnt++;
        if (dq.size() == 0) begin
          fail("unexpected_done");
        end else begin
          chk("done_after_last_we", 64'(prev_we), 64'(dq.pop_front()));
          chk("done_writes_drained", 64'(wq.size()), 0);
        end
      end
      prev_we = we;
    end
  end

  task automatic start_load(int cnt);
    pix_count = (AW+1)'(cnt);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(logic [7:0] b, int gap);
    int n;
    repeat (gap) @(negedge clk);
    s_data = b;
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      fail("s_ready_timeout");
      s_valid = 1'b0;
      return;
    end
    @(negedge clk);
    s_valid = 1'b0;
    chk("s_ready_low_unpack", 64'(s_ready), 0);
    if (wr_en(b[1:0])) chk("we_lane0_latency", 64'(we), 1);
  endtask

  task automatic wait_done(int exp_n);
    for (int n = 1; n <= 50; n++) begin
      @(negedge clk);
      if (done) begin
        chk("done_latency", 64'(n), 64'(exp_n));
        chk("busy_at_done", 64'(busy), 0);
        return;
      end
    end
    fail("done_timeout");
  endtask

  task automatic load(int cnt, bit throttle, int inj);
    logic [7:0] b;
    logic [1:0] pix;
    wr_t        e;
    int         nb;
    pix = 2'b00;
    for (int p = 0; p < cnt; p++) begin
      b = bq[p/PPB];
      pix = 2'(b >> (2*(p%PPB)));
      if (wr_en(pix)) begin
        e.a = AW'(p);
        e.d = pix;
        wq.push_back(e);
      end
    end
    dq.push_back((cnt == 0) ? 1'b0 : wr_en(pix));
    start_load(cnt);
    if (cnt == 0) begin
      chk("done_zero_count", 64'(done), 1);
      chk("s_ready_zero_count", 64'(s_ready), 0);
      chk("busy_zero_count", 64'(busy), 0);
      @(negedge clk);
      chk("done_one_cycle", 64'(done), 0);
      bq.delete();
      return;
    end
    chk("busy_after_start", 64'(busy), 1);
    chk("s_ready_after_start", 64'(s_ready), 1);
    nb = (cnt + PPB - 1) / PPB;
    for (int i = 0; i < nb; i++) begin
      if (i == inj) begin
        pix_count = (AW+1)'(5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      send(bq[i], throttle ? int'($urandom_range(0, 3)) : 0);
    end
    wait_done(((cnt - 1) % PPB) + 1);
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 0);
    chk("s_ready_idle", 64'(s_ready), 0);
    bq.delete();
  endtask

  initial begin
    wr_t e;
    repeat (2) @(negedge clk);
    chk("rst_s_ready", 64'(s_ready), 0);
    chk("rst_we", 64'(we), 0);
    chk("rst_addr_w", 64'(addr_w), 0);
    chk("rst_din", 64'(din), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", 64'(busy), 0);
    chk("idle_s_ready", 64'(s_ready), 0);

    bq = '{8'hE4, 8'h1B};
    load(8, 1'b0, -1);

    bq = '{8'hFF, 8'hAA};
    load(6, 1'b0, -1);

    load(0, 1'b0, -1);

    for (int i = 0; i < 256; i++) bq.push_back(8'(i*37 + 11));
    load(1024, 1'b1, 100);
    repeat (4) @(negedge clk);

    // Abort during the third pixel of a byte.
    start_load(8);
    e.a = AW'(0); e.d = 2'd0; if (wr_en(e.d)) wq.push_back(e);
    e.a = AW'(1); e.d = 2'd1; wq.push_back(e);
    e.a = AW'(2); e.d = 2'd2; wq.push_back(e);
    s_data = 8'hE4;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("we_async_reset", 64'(we), 0);
    chk("busy_async_reset", 64'(busy), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_abort_busy", 64'(busy), 0);
    chk("post_abort_s_ready", 64'(s_ready), 0);
    chk("aborted_writes_seen", 64'(wq.size()), 0);
    bq = '{8'h1B};
    load(4, 1'b0, -1);

    bq = '{8'h30};
    load(4, 1'b0, -1);

    repeat (5) @(negedge clk);
    chk("leftover_writes", 64'(wq.size()), 0);
    chk("leftover_done", 64'(dq.size()), 0);
    chk("done_pulses", 64'(done_cnt), 6);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
